// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter: FSM encodings
// and counter sizing helpers.
package piso_serial_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int GAP_CW = 4;

  // Gap counter terminal value; a zero gap never enters ST_GAP, so any value works.
  function automatic logic [GAP_CW-1:0] gap_tc_value(input int gap);
    if (gap > 0) begin
      return GAP_CW'(gap - 1);
    end else begin
      return {GAP_CW{1'b0}};
    end
  endfunction

endpackage

// File: rtl/piso_serial_tx_bit_counter.sv
// Up-counter with synchronous clear-to-zero load, enable and a terminal-count flag.
module piso_serial_tx_bit_counter #(
  parameter int            CW = 2,
  parameter logic [CW-1:0] TC = {CW{1'b1}}
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    if (load) begin
      count_d = {CW{1'b0}};
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer so words can
// stream back-to-back; optional forced idle gap between words.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sdo,
  output logic             sframe,
  output logic             slast,
  output logic             busy
);

  localparam int                BCW     = $clog2(WIDTH);
  localparam logic [BCW-1:0]    BIT_TC  = BCW'(WIDTH - 1);
  localparam logic [GAP_CW-1:0] GAP_TC  = gap_tc_value(GAP);
  localparam bit                HAS_GAP = (GAP > 0);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             in_ready_q, in_ready_d;
  logic             sdo_q, sdo_d;
  logic             sframe_q, sframe_d;
  logic             slast_q, slast_d;

  logic             xfer_s, word_avail_s, load_s, bit_en_s, gap_load_s, gap_en_s;
  logic             bit_tc_s, gap_tc_s, out_bit_s;
  logic [WIDTH-1:0] load_word_s, shifted_s;

  piso_serial_tx_bit_counter #(.CW(BCW), .TC(BIT_TC)) u_bit_cnt (
    .clk    (clk),
    .clear  (clear),
    .load   (load_s),
    .enable (bit_en_s),
    .tc     (bit_tc_s)
  );

  piso_serial_tx_bit_counter #(.CW(GAP_CW), .TC(GAP_TC)) u_gap_cnt (
    .clk    (clk),
    .clear  (clear),
    .load   (gap_load_s),
    .enable (gap_en_s),
    .tc     (gap_tc_s)
  );

  // A held word always goes first; with an empty hold an arriving word bypasses it.
  always_comb begin
    xfer_s       = in_valid && in_ready_q;
    word_avail_s = hold_full_q || xfer_s;
    load_word_s  = hold_full_q ? hold_q : in_data;
    out_bit_s    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    shifted_s    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    load_s     = 1'b0;
    bit_en_s   = 1'b0;
    gap_load_s = 1'b0;
    gap_en_s   = 1'b0;
    sdo_d      = 1'b0;
    sframe_d   = 1'b0;
    slast_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (word_avail_s) begin
          load_s  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sdo_d    = out_bit_s;
        sframe_d = 1'b1;
        slast_d  = bit_tc_s;
        if (!bit_tc_s) begin
          bit_en_s = 1'b1;
        end else if (HAS_GAP) begin
          gap_load_s = 1'b1;
          state_d    = ST_GAP;
        end else if (word_avail_s) begin
          load_s  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!gap_tc_s) begin
          gap_en_s = 1'b1;
        end else if (word_avail_s) begin
          load_s  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // in_ready can only be high while the hold is empty, so a reload from hold
  // never coincides with a fresh transfer into it.
  always_comb begin
    if (load_s) begin
      shreg_d = load_word_s;
    end else if (bit_en_s) begin
      shreg_d = shifted_s;
    end else begin
      shreg_d = shreg_q;
    end
    if (load_s && hold_full_q) begin
      hold_full_d = 1'b0;
      hold_d      = hold_q;
    end else if (xfer_s && !load_s) begin
      hold_full_d = 1'b1;
      hold_d      = in_data;
    end else begin
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
    end
    in_ready_d = !hold_full_d;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      hold_q      <= {WIDTH{1'b0}};
      hold_full_q <= 1'b0;
      shreg_q     <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b0;
      sdo_q       <= 1'b0;
      sframe_q    <= 1'b0;
      slast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      in_ready_q  <= in_ready_d;
      sdo_q       <= sdo_d;
      sframe_q    <= sframe_d;
      slast_q     <= slast_d;
    end
  end

  assign in_ready = in_ready_q;
  assign sdo      = sdo_q;
  assign sframe   = sframe_q;
  assign slast    = slast_q;
  assign busy     = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: unit 0 MSB-first no gap, unit 1 LSB-first,
// unit 2 MSB-first with a 3-cycle gap.
module tb_piso_serial_tx;

  logic       clk;
  logic       clear;
  logic       va [3];
  logic [3:0] da [3];
  logic       rdy [3];
  logic       sdo_o [3];
  logic       sfr_o [3];
  logic       slast_o [3];
  logic       busy_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) dut_msb (
    .clk(clk), .clear(clear), .in_valid(va[0]), .in_ready(rdy[0]), .in_data(da[0]),
    .sdo(sdo_o[0]), .sframe(sfr_o[0]), .slast(slast_o[0]), .busy(busy_o[0]));

  piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0)) dut_lsb (
    .clk(clk), .clear(clear), .in_valid(va[1]), .in_ready(rdy[1]), .in_data(da[1]),
    .sdo(sdo_o[1]), .sframe(sfr_o[1]), .slast(slast_o[1]), .busy(busy_o[1]));

  piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(3)) dut_gap (
    .clk(clk), .clear(clear), .in_valid(va[2]), .in_ready(rdy[2]), .in_data(da[2]),
    .sdo(sdo_o[2]), .sframe(sfr_o[2]), .slast(slast_o[2]), .busy(busy_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // seq holds the expected serial bits, first bit in seq[3]
  task automatic send_single(input int u, input logic [3:0] word, input logic [3:0] seq, input string nm);
    va[u] = 1'b1;
    da[u] = word;
    step();
    va[u] = 1'b0;
    check({nm, "_lat_sframe"}, 32'(sfr_o[u]), 32'd0);
    check({nm, "_lat_busy"}, 32'(busy_o[u]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("%s_sdo%0d", nm, k), 32'(sdo_o[u]), 32'(seq[3-k]));
      check($sformatf("%s_sframe%0d", nm, k), 32'(sfr_o[u]), 32'd1);
      check($sformatf("%s_slast%0d", nm, k), 32'(slast_o[u]), (k == 3) ? 32'd1 : 32'd0);
    end
    step();
    check({nm, "_end_sframe"}, 32'(sfr_o[u]), 32'd0);
    check({nm, "_end_busy"}, 32'(busy_o[u]), 32'd0);
  endtask

  // per_cycle=0: each word is held until accepted; per_cycle=1: words[c] is
  // offered on cycle c regardless of in_ready.
  task automatic run_stream(input int u, input bit per_cycle, input int n_words,
                            input logic [3:0] words [8], input int ncyc,
                            output logic [63:0] bits, output logic [31:0] tr_f,
                            output logic [31:0] tr_d, output logic [31:0] rv,
                            output int nframe, output int first, output int last,
                            output int stalls, output int accepted);
    int  wi;
    bit  acc;
    bit  prev_stall;
    bits = 64'd0; tr_f = 32'd0; tr_d = 32'd0; rv = 32'd0;
    nframe = 0; first = -1; last = -1; stalls = 0; accepted = 0;
    wi = 0; prev_stall = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (per_cycle) begin
        va[u] = (c < n_words);
        da[u] = (c < n_words) ? words[c] : 4'd0;
      end else begin
        va[u] = (wi < n_words);
        da[u] = (wi < n_words) ? words[wi] : 4'd0;
      end
      rv  = {rv[30:0], rdy[u]};
      acc = va[u] && rdy[u];
      if (va[u] && !rdy[u] && !prev_stall) stalls++;
      prev_stall = va[u] && !rdy[u];
      step();
      if (acc) begin
        wi++;
        accepted++;
      end
      tr_f = {tr_f[30:0], sfr_o[u]};
      tr_d = {tr_d[30:0], sdo_o[u]};
      if (sfr_o[u]) begin
        bits = {bits[62:0], sdo_o[u]};
        nframe++;
        if (first < 0) first = c;
        last = c;
      end
    end
    va[u] = 1'b0;
  endtask

  logic [3:0]  wl [8];
  logic [63:0] bits;
  logic [31:0] tr_f, tr_d, rv;
  int          nframe, first, last, stalls, accepted;

  initial begin
    clear = 1'b1;
    for (int u = 0; u < 3; u++) begin
      va[u] = 1'b0;
      da[u] = 4'd0;
    end
    #12;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_sdo_u%0d", u), 32'(sdo_o[u]), 32'd0);
      check($sformatf("rst_sframe_u%0d", u), 32'(sfr_o[u]), 32'd0);
      check($sformatf("rst_slast_u%0d", u), 32'(slast_o[u]), 32'd0);
      check($sformatf("rst_busy_u%0d", u), 32'(busy_o[u]), 32'd0);
      check($sformatf("rst_ready_u%0d", u), 32'(rdy[u]), 32'd0);
    end
    clear = 1'b0;
    step();
    for (int u = 0; u < 3; u++) begin
      check($sformatf("post_rst_ready_u%0d", u), 32'(rdy[u]), 32'd1);
    end

    // single word, MSB first
    send_single(0, 4'b0011, 4'b0011, "single_msb");
    // single word, LSB first
    send_single(1, 4'b0111, 4'b1110, "single_lsb");

    // back-to-back streaming, valid held until accepted
    for (int i = 0; i < 8; i++) wl[i] = 4'd0;
    wl[0] = 4'b1011; wl[1] = 4'b1001; wl[2] = 4'b1111;
    run_stream(0, 1'b0, 3, wl, 20, bits, tr_f, tr_d, rv, nframe, first, last, stalls, accepted);
    check("stream_nframe", 32'(nframe), 32'd12);
    check("stream_contig", 32'(last - first + 1), 32'd12);
    check("stream_first", 32'(first), 32'd1);
    check("stream_bits", bits[31:0], 32'h0000_0B9F);
    check("stream_stalls", 32'(stalls), 32'd1);
    check("stream_accepted", 32'(accepted), 32'd3);

    // backpressure: data changes every cycle, only accepted words are sent
    wl[0] = 4'b1100; wl[1] = 4'b0101; wl[2] = 4'b1110;
    wl[3] = 4'b0010; wl[4] = 4'b1000; wl[5] = 4'b0110;
    run_stream(0, 1'b1, 6, wl, 20, bits, tr_f, tr_d, rv, nframe, first, last, stalls, accepted);
    check("bp_nframe", 32'(nframe), 32'd12);
    check("bp_contig", 32'(last - first + 1), 32'd12);
    check("bp_bits", bits[31:0], 32'h0000_0C56);
    check("bp_ready_trace", rv & 32'h000F_FFFF, 32'h000C_47FF);
    check("bp_accepted", 32'(accepted), 32'd3);

    // forced gap of 3 idle cycles between words
    for (int i = 0; i < 8; i++) wl[i] = 4'd0;
    wl[0] = 4'b0001; wl[1] = 4'b1111;
    run_stream(2, 1'b0, 2, wl, 16, bits, tr_f, tr_d, rv, nframe, first, last, stalls, accepted);
    check("gap_sframe_trace", tr_f & 32'h0000_FFFF, 32'h0000_78F0);
    check("gap_sdo_trace", tr_d & 32'h0000_FFFF, 32'h0000_08F0);
    check("gap_idle_cycles", 32'(last - first + 1 - nframe), 32'd3);
    check("gap_bits", bits[31:0], 32'h0000_001F);

    // clear in the middle of a word
    va[0] = 1'b1;
    da[0] = 4'b1011;
    step();
    va[0] = 1'b0;
    step();
    check("mid_bit0", 32'(sdo_o[0]), 32'd1);
    step();
    check("mid_bit1", 32'(sdo_o[0]), 32'd0);
    check("mid_busy_before", 32'(busy_o[0]), 32'd1);
    #2;
    clear = 1'b1;
    #1;
    check("mid_clr_sdo", 32'(sdo_o[0]), 32'd0);
    check("mid_clr_sframe", 32'(sfr_o[0]), 32'd0);
    check("mid_clr_slast", 32'(slast_o[0]), 32'd0);
    check("mid_clr_busy", 32'(busy_o[0]), 32'd0);
    check("mid_clr_ready", 32'(rdy[0]), 32'd0);
    #2;
    clear = 1'b0;
    step();
    check("mid_post_ready", 32'(rdy[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mid_no_stale%0d", k), 32'(sfr_o[0]), 32'd0);
      step();
    end
    check("mid_post_busy", 32'(busy_o[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
